// File: rtl/kcalc_pkg.sv
// Shared key codes, FSM state and operator encodings for the keypad calculator.
// Helper functions classify a raw key code so the datapath reads in terms of intent.
package kcalc_pkg;

  localparam logic [3:0] KEY_CONFIRM   = 4'hA;
  localparam logic [3:0] KEY_CLR_ENTRY = 4'hB;
  localparam logic [3:0] KEY_CLR_ALL   = 4'hC;
  localparam logic [3:0] KEY_MUL       = 4'hD;
  localparam logic [3:0] KEY_ADD       = 4'hE;
  localparam logic [3:0] KEY_SUB       = 4'hF;

  typedef enum logic [2:0] {
    CAP_A,
    CAP_B,
    WAIT_OP,
    COMPUTE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL
  } op_t;

  function automatic logic is_digit_key(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  function automatic logic is_op_key(input logic [3:0] key);
    return key >= KEY_MUL;
  endfunction

  function automatic op_t key_to_op(input logic [3:0] key);
    op_t op;
    case (key)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      default: op = OP_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle; W cycles from start to done.
// No backpressure: done strobes during the final iteration, product then holds until clear/start.
module seq_mult #(
  parameter int W = 14
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           clear,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CNTW = $clog2(W + 1);

  logic             busy_q;
  logic [CNTW-1:0]  cnt_q;
  logic [2*W-1:0]   mcand_q;
  logic [W-1:0]     mplier_q;
  logic [2*W-1:0]   acc_q;
  logic [2*W-1:0]   partial;
  logic [2*W-1:0]   sum;

  // product includes the in-flight partial so the final value is capturable on the done cycle
  assign partial = (busy_q && mplier_q[0]) ? mcand_q : '0;
  assign sum     = acc_q + partial;
  assign done    = busy_q && (cnt_q == CNTW'(W - 1));
  assign busy    = busy_q;
  assign product = sum;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_operand_calc.sv
// Keypad calculator front end: captures two decimal operands, then adds, subtracts or multiplies.
// Key effects land one cycle after the key edge; multiply takes OPW cycles; no backpressure.
module keypad_operand_calc
  import kcalc_pkg::*;
#(
  parameter int  N_DIGITS = 4,
  localparam int OPW      = $clog2(10 ** N_DIGITS),
  localparam int RW       = 2 * OPW,
  localparam int CW       = $clog2(N_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_pressed,
  input  logic [3:0]    key_value,
  output logic [OPW-1:0] operand_a,
  output logic [OPW-1:0] operand_b,
  output logic [CW-1:0] digit_cnt,
  output logic          show_a,
  output logic          show_b,
  output logic          show_res,
  output logic [RW-1:0] result,
  output logic          negative,
  output logic          busy,
  output logic          result_valid,
  output logic          done_pulse
);

  state_t state, state_nxt;

  logic            key_pressed_q;
  logic            key_valid;
  logic            wipe;
  logic            mult_start;
  logic            mult_busy;
  logic            mult_done;
  logic [RW-1:0]   mult_product;
  logic [OPW-1:0]  cur_entry;
  logic [OPW+3:0]  entry_ext;
  logic [OPW-1:0]  entry_nxt;
  logic            cnt_full;
  logic            leading_zero;

  assign key_valid = key_pressed & ~key_pressed_q;

  // Clear-all anywhere, or confirm after a result, returns everything to a blank calculator
  assign wipe = key_valid && ((key_value == KEY_CLR_ALL) ||
                              (state == DONE && key_value == KEY_CONFIRM));

  assign mult_start = key_valid && (state == WAIT_OP) && (key_value == KEY_MUL);

  assign cur_entry    = (state == CAP_B) ? operand_b : operand_a;
  assign entry_ext    = ({4'b0, cur_entry} << 3) + ({4'b0, cur_entry} << 1) +
                        {{OPW{1'b0}}, key_value};
  assign entry_nxt    = entry_ext[OPW-1:0];
  assign cnt_full     = (digit_cnt == CW'(N_DIGITS));
  assign leading_zero = (cur_entry == '0) && (digit_cnt == '0) && (key_value == 4'd0);

  seq_mult #(.W(OPW)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .clear   (wipe),
    .a       (operand_a),
    .b       (operand_b),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_product)
  );

  assign busy = mult_busy;

  always_ff @(posedge clk) begin
    if (!rst) state <= CAP_A;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wipe) begin
      state_nxt = CAP_A;
    end else begin
      case (state)
        CAP_A:   if (key_valid && key_value == KEY_CONFIRM) state_nxt = CAP_B;
        CAP_B:   if (key_valid && key_value == KEY_CONFIRM) state_nxt = WAIT_OP;
        WAIT_OP: if (key_valid && is_op_key(key_value))
                   state_nxt = (key_value == KEY_MUL) ? COMPUTE : DONE;
        COMPUTE: if (mult_done) state_nxt = DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    show_a       = 1'b0;
    show_b       = 1'b0;
    show_res     = 1'b0;
    result_valid = 1'b0;
    case (state)
      CAP_A:          show_a = 1'b1;
      CAP_B, WAIT_OP: show_b = 1'b1;
      COMPUTE:        show_res = 1'b1;
      DONE: begin
        show_res     = 1'b1;
        result_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_pressed_q <= 1'b0;
      operand_a     <= '0;
      operand_b     <= '0;
      digit_cnt     <= '0;
      result        <= '0;
      negative      <= 1'b0;
      done_pulse    <= 1'b0;
    end else begin
      key_pressed_q <= key_pressed;
      done_pulse    <= (state_nxt == DONE) && (state != DONE);
      if (wipe) begin
        operand_a <= '0;
        operand_b <= '0;
        digit_cnt <= '0;
        result    <= '0;
        negative  <= 1'b0;
      end else begin
        case (state)
          CAP_A, CAP_B: begin
            if (key_valid && is_digit_key(key_value)) begin
              if (!cnt_full) begin
                if (state == CAP_A) operand_a <= entry_nxt;
                else                operand_b <= entry_nxt;
                if (!leading_zero) digit_cnt <= digit_cnt + 1'b1;
              end
            end else if (key_valid && key_value == KEY_CLR_ENTRY) begin
              if (state == CAP_A) operand_a <= '0;
              else                operand_b <= '0;
              digit_cnt <= '0;
            end else if (key_valid && key_value == KEY_CONFIRM) begin
              digit_cnt <= '0;
            end
          end
          WAIT_OP: begin
            if (key_valid && is_op_key(key_value)) begin
              negative <= 1'b0;
              case (key_to_op(key_value))
                OP_ADD: result <= RW'(operand_a) + RW'(operand_b);
                OP_SUB: begin
                  result   <= (operand_b > operand_a) ? RW'(operand_b - operand_a)
                                                      : RW'(operand_a - operand_b);
                  negative <= (operand_b > operand_a);
                end
                default: result <= '0;
              endcase
            end
          end
          COMPUTE: if (mult_done) result <= mult_product;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_operand_calc.md
# keypad_operand_calc

Parametrised two-operand keypad calculator front end. It sits between the keypad scanner/debouncer and the display/BCD conversion path. It edge-detects key strobes and accumulates two decimal operands of up to N_DIGITS digits each. On an operator key it computes A+B, |A−B| (with a sign flag) or A×B, using a sequential shift-add multiplier, and presents the result with a valid/busy handshake.

## Interface
Parameters and derived constants:
- N_DIGITS, default 4: maximum decimal digits per operand, legal range 1–9.
- OPW (localparam), $clog2(10**N_DIGITS): operand width in bits; 14 when N_DIGITS = 4.
- RW (localparam), 2*OPW: result width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- key_pressed  in  1  debounced key-held level.
- key_value  in  4  key code: 0–9 digits, A confirm, B clear entry, C clear all, D multiply, E add, F subtract.
- operand_a  out  OPW  binary value of operand A.
- operand_b  out  OPW  binary value of operand B.
- digit_cnt  out  $clog2(N_DIGITS+1)  number of digits in the entry currently being captured.
- show_a / show_b / show_res  out  1  one-hot display select.
- result  out  RW  computed result, registered.
- negative  out  1  set when a subtraction has B > A.
- busy  out  1  high while the multiplier is running.
- result_valid  out  1  level; high in DONE.
- done_pulse  out  1  single-cycle pulse on entry to DONE.

## Operation
- key_valid = key_pressed & ~key_pressed_q. Only key_valid cycles act; a held key acts once.
- FSM states: CAP_A, CAP_B, WAIT_OP, COMPUTE, DONE.
- CAP_A and CAP_B, digit key:
  - Entry value <= value*10 + digit, and digit_cnt increments.
  - A '0' entered on an empty entry (value 0, digit_cnt 0) leaves digit_cnt at 0.
  - When digit_cnt == N_DIGITS, further digits are ignored: value and count are unchanged.
- Key A: CAP_A→CAP_B (digit_cnt cleared). CAP_B→WAIT_OP. DONE→CAP_A with both operands, result and negative cleared.
- Key B: clears the current entry (value and digit_cnt) in CAP_A/CAP_B. Ignored in other states.
- Key C: from any state, including mid-COMPUTE, goes to CAP_A. Clears operands, result, negative and the multiplier, and deasserts busy the next cycle.
- Operator keys D/E/F are accepted only in WAIT_OP and ignored elsewhere.
  - E: result <= A+B, zero-extended to RW bits.
  - F: result <= |A−B|; negative <= (B > A).
  - D: COMPUTE, running OPW shift-add iterations, one multiplier bit per cycle. Product width is RW; overflow cannot occur.
- Display selects:
  - show_a = 1 in CAP_A.
  - show_b = 1 in CAP_B and WAIT_OP.
  - show_res = 1 in COMPUTE and DONE.
- Key codes not listed for the current state are ignored.

## Timing
- Reset: state CAP_A; all outputs 0 except show_a = 1.
- Digit/clear/confirm: the effect is visible the cycle after the key_valid cycle.
- E/F: result, result_valid and done_pulse are visible the cycle after key_valid (latency 1); busy never rises.
- D: busy rises the cycle after key_valid and stays high OPW cycles. result_valid and done_pulse rise OPW+1 cycles after key_valid, and busy falls in the same cycle.
- result holds stable while result_valid is high. result_valid drops the cycle after an accepted A or C.
- Reset asserted mid-operation overrides everything in that cycle.
- key_valid in the same cycle as the final multiply iteration: the key is ignored unless it is C, which wins.

## Structure
- Shared package kcalc_pkg:
  - key code constants: KEY_CONFIRM = 4'hA, KEY_CLR_ENTRY, KEY_CLR_ALL, KEY_MUL, KEY_ADD, KEY_SUB;
  - state enum typedef;
  - op enum {OP_ADD, OP_SUB, OP_MUL}.
- Sub-module seq_mult #(W): inputs start, a, b and sync clear; outputs busy, done and product[2W−1:0]; takes W cycles. Reusable elsewhere.

## Test plan
- N_DIGITS=4: keys 1,2,3,4,5 (edges) → operand_a = 1234, digit_cnt = 4; the fifth digit is ignored.
- A=25, B=4, key E → result = 29 one cycle after key_valid; done_pulse lasts one cycle; busy stays 0.
- A=7, B=19, key F → result = 12, negative = 1; then key A → all cleared, show_a = 1.
- A=9999, B=9999, key D → busy for 14 cycles, then result = 99980001, result_valid = 1.
- Key C at iteration 5 of a multiply → next cycle busy = 0, state CAP_A, result = 0, no done_pulse.
- key_pressed held high 20 cycles on '3' → exactly one digit accepted. Key B in CAP_B → operand_b = 0, digit_cnt = 0.
